dot_feeder: RTL and testbench

DOT_FEEDER -- requirements
Module: dot_feeder

---
 rtl/dot_feeder.sv | 134 +++++++++++++
 tb/tb_dot_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_feeder.sv
// Collects element pairs into LANES-wide a/b vectors for a dot-product datapath, then
// captures the returned result and holds it until the consumer accepts. Macro DOT_FEEDER_SHORT_EN enables short vectors.
module dot_feeder #(
    parameter int LANES   = 16,
    parameter int ELEM_W  = 32,
    parameter int Y_W     = 69,
    parameter int LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [ELEM_W-1:0]       io_in_a,
    input  logic [ELEM_W-1:0]       io_in_b,
    input  logic                    io_in_last,
    output logic [LANES*ELEM_W-1:0] io_vec_a,
    output logic [LANES*ELEM_W-1:0] io_vec_b,
    input  logic [Y_W-1:0]          io_dp_y,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [Y_W-1:0]          io_out_bits,
    output logic                    io_busy
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [Y_W-1:0]     out_bits_reg;
    logic [ELEM_W-1:0]  a_lane_reg [LANES];
    logic [ELEM_W-1:0]  b_lane_reg [LANES];

    logic handshake;
    logic capture;
    logic end_of_vector;

`ifdef DOT_FEEDER_SHORT_EN
    assign end_of_vector = (idx_reg == LAST_IDX) || io_in_last;
`else
    logic unused_in_last;
    assign unused_in_last = io_in_last;
    assign end_of_vector  = (idx_reg == LAST_IDX);
`endif

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wait_cnt_next = wait_cnt_reg;
        io_in_ready   = 1'b0;
        handshake     = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            FILL: begin
                io_in_ready = 1'b1;
                handshake   = io_in_valid;
                if (io_in_valid) begin
                    if (end_of_vector) begin
                        idx_next      = '0;
                        wait_cnt_next = CNT_W'(LATENCY);
                        state_next    = WAIT;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            WAIT: begin
                // The counter reaching zero marks the cycle io_dp_y reflects the held vectors.
                if (wait_cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else begin
                    wait_cnt_next = wait_cnt_reg - CNT_W'(1);
                end
            end
            HOLD: begin
                if (io_out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= FILL;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
            out_bits_reg <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            wait_cnt_reg <= wait_cnt_next;
            if (capture) begin
                out_bits_reg <= io_dp_y;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [IDX_W-1:0] LANE_ID = IDX_W'(gi);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_lane_reg[gi] <= '0;
                    b_lane_reg[gi] <= '0;
                end else if (handshake && (idx_reg == LANE_ID)) begin
                    a_lane_reg[gi] <= io_in_a;
                    b_lane_reg[gi] <= io_in_b;
`ifdef DOT_FEEDER_SHORT_EN
                end else if (handshake && io_in_last && (LANE_ID > idx_reg)) begin
                    // Lanes beyond a short vector's end must not contribute stale data.
                    a_lane_reg[gi] <= '0;
                    b_lane_reg[gi] <= '0;
`endif
                end
            end

            assign io_vec_a[gi*ELEM_W +: ELEM_W] = a_lane_reg[gi];
            assign io_vec_b[gi*ELEM_W +: ELEM_W] = b_lane_reg[gi];
        end
    endgenerate

    assign io_out_valid = (state_reg == HOLD);
    assign io_out_bits  = out_bits_reg;
    assign io_busy      = (state_reg != FILL) || (idx_reg != '0);

endmodule

// File: tb/tb_dot_feeder.sv
// Directed bench for dot_feeder: a two-stage dot-product model closes the loop from io_vec_a/b to io_dp_y.
module tb_dot_feeder;

    localparam int LANES  = 16;
    localparam int ELEM_W = 32;
    localparam int Y_W    = 69;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    io_in_valid;
    logic                    io_in_ready;
    logic [ELEM_W-1:0]       io_in_a;
    logic [ELEM_W-1:0]       io_in_b;
    logic                    io_in_last;
    logic [LANES*ELEM_W-1:0] io_vec_a;
    logic [LANES*ELEM_W-1:0] io_vec_b;
    logic [Y_W-1:0]          io_dp_y;
    logic                    io_out_valid;
    logic                    io_out_ready;
    logic [Y_W-1:0]          io_out_bits;
    logic                    io_busy;

    int vectors    = 0;
    int miscompares = 0;

    dot_feeder #(.LANES(LANES), .ELEM_W(ELEM_W), .Y_W(Y_W), .LATENCY(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_a      (io_in_a),
        .io_in_b      (io_in_b),
        .io_in_last   (io_in_last),
        .io_vec_a     (io_vec_a),
        .io_vec_b     (io_vec_b),
        .io_dp_y      (io_dp_y),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_busy      (io_busy)
    );

    always #5 clock = ~clock;

    // Datapath model: unsigned dot product behind two register stages.
    logic [Y_W-1:0] dot_comb, y_s1, y_s2;
    always_comb begin
        dot_comb = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_comb = dot_comb + Y_W'(io_vec_a[i*ELEM_W +: ELEM_W]) * Y_W'(io_vec_b[i*ELEM_W +: ELEM_W]);
        end
    end
    always @(posedge clock) begin
        y_s1 <= dot_comb;
        y_s2 <= y_s1;
    end
    assign io_dp_y = y_s2;

    task automatic send_pair(input logic [ELEM_W-1:0] a, input logic [ELEM_W-1:0] b, input logic last);
        io_in_valid = 1'b1;
        io_in_a     = a;
        io_in_b     = b;
        io_in_last  = last;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!io_out_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic release_result();
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_a      = '0;
        io_in_b      = '0;
        io_in_last   = 1'b0;
        io_out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", io_out_valid); end
        vectors++; if (io_out_bits !== '0) begin miscompares++; $display("FAIL reset_out_bits got %0d want 0", io_out_bits); end
        vectors++; if (io_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", io_in_ready); end
        vectors++; if (io_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", io_busy); end
        vectors++; if (io_vec_a !== '0 || io_vec_b !== '0) begin miscompares++; $display("FAIL reset_vectors nonzero, want all 0"); end
        reset = 1'b0;
        $display("reset: checks done");
    endtask

    task automatic test_full_vector();
        int n;
        for (int i = 0; i < LANES; i++) begin
            send_pair(ELEM_W'(i + 1), 32'd2, 1'b0);
            if (i == 0) begin
                vectors++; if (io_busy !== 1'b1) begin miscompares++; $display("FAIL full_busy_after_first got %b want 1", io_busy); end
            end
        end
        vectors++; if (io_in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_in_wait got %b want 0", io_in_ready); end
        wait_valid(n);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL full_latency got %0d want 3", n); end
        vectors++; if (io_out_bits !== 69'd272) begin miscompares++; $display("FAIL full_result got %0d want 272", io_out_bits); end
        vectors++; if (io_vec_a[15*ELEM_W +: ELEM_W] !== 32'd16) begin miscompares++; $display("FAIL full_lane15_a got %0d want 16", io_vec_a[15*ELEM_W +: ELEM_W]); end
        release_result();
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL full_valid_after_release got %b want 0", io_out_valid); end
        vectors++; if (io_in_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_release got %b want 1", io_in_ready); end
        vectors++; if (io_busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_after_release got %b want 0", io_busy); end
        $display("full_vector: latency %0d result %0d", n, io_out_bits);
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < LANES; i++) begin
            send_pair(ELEM_W'(i), ELEM_W'(i + 1), 1'b0);
        end
        wait_valid(n);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL bp_latency got %0d want 3", n); end
        vectors++; if (io_out_bits !== 69'd1360) begin miscompares++; $display("FAIL bp_result got %0d want 1360", io_out_bits); end
        for (int c = 0; c < 10; c++) begin
            io_in_valid = 1'b1;
            io_in_a     = 32'hdead_beef;
            io_in_b     = 32'h1234_5678;
            @(posedge clock);
            #1;
            vectors++; if (io_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, io_out_valid); end
            vectors++; if (io_out_bits !== 69'd1360) begin miscompares++; $display("FAIL bp_hold_bits cycle %0d got %0d want 1360", c, io_out_bits); end
            vectors++; if (io_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready cycle %0d got %b want 0", c, io_in_ready); end
        end
        io_in_valid = 1'b0;
        vectors++; if (io_vec_a[0 +: ELEM_W] !== 32'd0) begin miscompares++; $display("FAIL bp_lane0_untouched got %h want 0", io_vec_a[0 +: ELEM_W]); end
        release_result();
        vectors++; if (io_in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_release got %b want 1", io_in_ready); end
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after_release got %b want 0", io_out_valid); end
        $display("backpressure: held 10 cycles, result %0d", io_out_bits);
    endtask

    task automatic test_last();
        int n;
        send_pair(32'd1, 32'd1, 1'b0);
        send_pair(32'd2, 32'd2, 1'b0);
        send_pair(32'd3, 32'd3, 1'b1);
`ifdef DOT_FEEDER_SHORT_EN
        for (int i = 3; i < LANES; i++) begin
            vectors++;
            if (io_vec_a[i*ELEM_W +: ELEM_W] !== '0 || io_vec_b[i*ELEM_W +: ELEM_W] !== '0) begin
                miscompares++;
                $display("FAIL short_zero_lane%0d got a=%0d b=%0d want 0", i, io_vec_a[i*ELEM_W +: ELEM_W], io_vec_b[i*ELEM_W +: ELEM_W]);
            end
        end
        wait_valid(n);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL short_latency got %0d want 3", n); end
        vectors++; if (io_out_bits !== 69'd14) begin miscompares++; $display("FAIL short_result got %0d want 14", io_out_bits); end
`else
        vectors++; if (io_in_ready !== 1'b1) begin miscompares++; $display("FAIL last_ignored_ready got %b want 1", io_in_ready); end
        vectors++; if (io_busy !== 1'b1) begin miscompares++; $display("FAIL last_ignored_busy got %b want 1", io_busy); end
        for (int i = 3; i < LANES - 1; i++) begin
            send_pair(32'd1, 32'd1, 1'b0);
        end
        vectors++; if (io_in_ready !== 1'b1) begin miscompares++; $display("FAIL last_15_ready got %b want 1", io_in_ready); end
        send_pair(32'd1, 32'd1, 1'b0);
        wait_valid(n);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL last_latency got %0d want 3", n); end
        vectors++; if (io_out_bits !== 69'd27) begin miscompares++; $display("FAIL last_result got %0d want 27", io_out_bits); end
`endif
        release_result();
        $display("last: result %0d", io_out_bits);
    endtask

    task automatic test_reset_in_wait();
        int n;
        for (int i = 0; i < LANES; i++) begin
            send_pair(32'd5, ELEM_W'(i + 1), 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_valid got %b want 0", io_out_valid); end
        vectors++; if (io_vec_a !== '0 || io_vec_b !== '0) begin miscompares++; $display("FAIL rst_wait_vectors nonzero, want all 0"); end
        vectors++; if (io_busy !== 1'b0) begin miscompares++; $display("FAIL rst_wait_busy got %b want 0", io_busy); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_pair(32'd3, 32'd0, 1'b0);
        vectors++; if (io_vec_a[0 +: ELEM_W] !== 32'd3) begin miscompares++; $display("FAIL rst_wait_lane0 got %0d want 3", io_vec_a[0 +: ELEM_W]); end
        for (int i = 1; i < LANES; i++) begin
            send_pair(32'd3, ELEM_W'(i), 1'b0);
        end
        wait_valid(n);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL rst_wait_latency got %0d want 3", n); end
        vectors++; if (io_out_bits !== 69'd360) begin miscompares++; $display("FAIL rst_wait_result got %0d want 360", io_out_bits); end
        release_result();
        $display("reset_in_wait: result %0d", io_out_bits);
    endtask

    task automatic test_random_valid();
        int n;
        int i = 0;
        while (i < LANES) begin
            if ($urandom_range(0, 1) == 1) begin
                send_pair(ELEM_W'(100 + i), 32'd7, 1'b0);
                i++;
            end else begin
                io_in_valid = 1'b0;
                io_in_a     = $urandom;
                io_in_b     = $urandom;
                io_in_last  = 1'b1;
                @(posedge clock);
                #1;
                io_in_last  = 1'b0;
            end
        end
        wait_valid(n);
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL rand_latency got %0d want 3", n); end
        for (int k = 0; k < LANES; k++) begin
            vectors++;
            if (io_vec_a[k*ELEM_W +: ELEM_W] !== ELEM_W'(100 + k) || io_vec_b[k*ELEM_W +: ELEM_W] !== 32'd7) begin
                miscompares++;
                $display("FAIL rand_lane%0d got a=%0d b=%0d want a=%0d b=7", k, io_vec_a[k*ELEM_W +: ELEM_W], io_vec_b[k*ELEM_W +: ELEM_W], 100 + k);
            end
        end
        vectors++; if (io_out_bits !== 69'd12040) begin miscompares++; $display("FAIL rand_result got %0d want 12040", io_out_bits); end
        release_result();
        $display("random_valid: result %0d", io_out_bits);
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_backpressure();
        test_last();
        test_reset_in_wait();
        test_random_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
